// File: rtl/axi_read_port_arbiter.sv
// axi_read_port_arbiter
// Shares one burst read master between two command sources. Each source
// owns a one-deep command slot; slots are served round-robin, one burst at
// a time, and returned beats are steered only to the requester that owns
// the burst currently in flight.
module axi_read_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_start,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [LEN_WIDTH-1:0]  req0_len,
    input  logic [2:0]            req0_size,
    input  logic [1:0]            req0_burst,
    input  logic                  req1_start,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [LEN_WIDTH-1:0]  req1_len,
    input  logic [2:0]            req1_size,
    input  logic [1:0]            req1_burst,
    output logic                  start_read,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [LEN_WIDTH-1:0]  read_len,
    output logic [2:0]            read_size,
    output logic [1:0]            read_burst,
    input  logic                  rvalid,
    input  logic                  rlast,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  req0_rvalid,
    output logic                  req1_rvalid,
    output logic                  req0_rlast,
    output logic                  req1_rlast,
    output logic [DATA_WIDTH-1:0] req_rdata,
    output logic                  grant,
    output logic                  busy,
    output logic [1:0]            overflow,
    output logic                  stray_beat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] slotAddr_q [2];
    logic [ADDR_WIDTH-1:0] slotAddr_d [2];
    logic [LEN_WIDTH-1:0]  slotLen_q [2];
    logic [LEN_WIDTH-1:0]  slotLen_d [2];
    logic [2:0]            slotSize_q [2];
    logic [2:0]            slotSize_d [2];
    logic [1:0]            slotBurst_q [2];
    logic [1:0]            slotBurst_d [2];
    logic                  lastGrant_q, lastGrant_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] readAddr_q, readAddr_d;
    logic [LEN_WIDTH-1:0]  readLen_q, readLen_d;
    logic [2:0]            readSize_q, readSize_d;
    logic [1:0]            readBurst_q, readBurst_d;
    logic [1:0]            overflow_q, overflow_d;
    logic                  stray_q, stray_d;

    logic [1:0]            reqStart;
    logic [ADDR_WIDTH-1:0] reqAddr [2];
    logic [LEN_WIDTH-1:0]  reqLen [2];
    logic [2:0]            reqSize [2];
    logic [1:0]            reqBurst [2];
    logic                  winner;
    logic                  grantNow;

    assign reqStart    = {req1_start, req0_start};
    assign reqAddr[0]  = req0_addr;
    assign reqAddr[1]  = req1_addr;
    assign reqLen[0]   = req0_len;
    assign reqLen[1]   = req1_len;
    assign reqSize[0]  = req0_size;
    assign reqSize[1]  = req1_size;
    assign reqBurst[0] = req0_burst;
    assign reqBurst[1] = req1_burst;

    // Round-robin pick: a lone pending slot wins, a tie goes to whoever was not served last
    always_comb begin
        winner   = pending_q[1];
        grantNow = 1'b0;
        if (pending_q == 2'b11) begin
            winner = ~lastGrant_q;
        end
        if ((state_q == ST_IDLE) && (pending_q != 2'b00)) begin
            grantNow = 1'b1;
        end
    end

    // Next-state logic: FSM sequencing, grant loading, slot capture and sticky error flags
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        slotAddr_d  = slotAddr_q;
        slotLen_d   = slotLen_q;
        slotSize_d  = slotSize_q;
        slotBurst_d = slotBurst_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        readAddr_d  = readAddr_q;
        readLen_d   = readLen_q;
        readSize_d  = readSize_q;
        readBurst_d = readBurst_q;
        overflow_d  = overflow_q;
        stray_d     = stray_q;

        case (state_q)
            ST_IDLE: begin
                if (grantNow) begin
                    state_d            = ST_ISSUE;
                    grant_d            = winner;
                    lastGrant_d        = winner;
                    readAddr_d         = slotAddr_q[winner];
                    readLen_d          = slotLen_q[winner];
                    readSize_d         = slotSize_q[winner];
                    readBurst_d        = slotBurst_q[winner];
                    pending_d[winner]  = 1'b0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rvalid && rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A slot being granted this cycle is already free, so a new command may refill it
        for (int i = 0; i < 2; i++) begin
            if (reqStart[i]) begin
                if (!pending_q[i] || (grantNow && (winner == 1'(i)))) begin
                    pending_d[i]   = 1'b1;
                    slotAddr_d[i]  = reqAddr[i];
                    slotLen_d[i]   = reqLen[i];
                    slotSize_d[i]  = reqSize[i];
                    slotBurst_d[i] = reqBurst[i];
                end else begin
                    overflow_d[i] = 1'b1;
                end
            end
        end

        if (rvalid && (state_q != ST_WAIT)) begin
            stray_d = 1'b1;
        end
    end

    // State and slot registers; reset discards any queued commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 2'b00;
            slotAddr_q  <= '{default: '0};
            slotLen_q   <= '{default: '0};
            slotSize_q  <= '{default: '0};
            slotBurst_q <= '{default: '0};
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            readAddr_q  <= '0;
            readLen_q   <= '0;
            readSize_q  <= '0;
            readBurst_q <= '0;
            overflow_q  <= 2'b00;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            slotAddr_q  <= slotAddr_d;
            slotLen_q   <= slotLen_d;
            slotSize_q  <= slotSize_d;
            slotBurst_q <= slotBurst_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            readAddr_q  <= readAddr_d;
            readLen_q   <= readLen_d;
            readSize_q  <= readSize_d;
            readBurst_q <= readBurst_d;
            overflow_q  <= overflow_d;
            stray_q     <= stray_d;
        end
    end

    assign start_read  = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign grant       = grant_q;
    assign read_addr   = readAddr_q;
    assign read_len    = readLen_q;
    assign read_size   = readSize_q;
    assign read_burst  = readBurst_q;
    assign overflow    = overflow_q;
    assign stray_beat  = stray_q;

    assign req0_rvalid = rvalid & (state_q == ST_WAIT) & ~grant_q;
    assign req1_rvalid = rvalid & (state_q == ST_WAIT) &  grant_q;
    assign req0_rlast  = rlast  & (state_q == ST_WAIT) & ~grant_q;
    assign req1_rlast  = rlast  & (state_q == ST_WAIT) &  grant_q;
    assign req_rdata   = rdata;

endmodule

// File: tb/tb_axi_read_port_arbiter.sv
// Directed testbench for axi_read_port_arbiter. Each scenario task drives its
// own stimulus and compares outputs against hand-computed values.
module tb_axi_read_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_start, req1_start;
    logic [31:0] req0_addr, req1_addr;
    logic [31:0] req0_len, req1_len;
    logic [2:0]  req0_size, req1_size;
    logic [1:0]  req0_burst, req1_burst;
    logic        start_read;
    logic [31:0] read_addr;
    logic [31:0] read_len;
    logic [2:0]  read_size;
    logic [1:0]  read_burst;
    logic        rvalid, rlast;
    logic [31:0] rdata;
    logic        req0_rvalid, req1_rvalid, req0_rlast, req1_rlast;
    logic [31:0] req_rdata;
    logic        grant, busy;
    logic [1:0]  overflow;
    logic        stray_beat;

    int testsRun    = 0;
    int testsFailed = 0;

    axi_read_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LEN_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_start (req0_start),
        .req0_addr  (req0_addr),
        .req0_len   (req0_len),
        .req0_size  (req0_size),
        .req0_burst (req0_burst),
        .req1_start (req1_start),
        .req1_addr  (req1_addr),
        .req1_len   (req1_len),
        .req1_size  (req1_size),
        .req1_burst (req1_burst),
        .start_read (start_read),
        .read_addr  (read_addr),
        .read_len   (read_len),
        .read_size  (read_size),
        .read_burst (read_burst),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .rdata      (rdata),
        .req0_rvalid(req0_rvalid),
        .req1_rvalid(req1_rvalid),
        .req0_rlast (req0_rlast),
        .req1_rlast (req1_rlast),
        .req_rdata  (req_rdata),
        .grant      (grant),
        .busy       (busy),
        .overflow   (overflow),
        .stray_beat (stray_beat)
    );

    // Free-running 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land 1 unit past the rising edge, away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release it, and settle in an idle cycle
    task automatic resetDut();
        rst_n      = 1'b0;
        req0_start = 1'b0;
        req1_start = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rdata      = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Present a one-cycle command on either or both requesters
    task automatic pulseReq(input logic s0, input logic [31:0] a0, input logic [31:0] l0,
                            input logic s1, input logic [31:0] a1, input logic [31:0] l1);
        req0_start = s0;
        req0_addr  = a0;
        req0_len   = l0;
        req1_start = s1;
        req1_addr  = a1;
        req1_len   = l1;
        tick();
        req0_start = 1'b0;
        req1_start = 1'b0;
    endtask

    // Return n beats back to back, the last one flagged rlast
    task automatic driveBeats(input int n);
        for (int k = 0; k < n; k++) begin
            rvalid = 1'b1;
            rlast  = (k == n - 1);
            rdata  = 32'(k);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    // Asynchronous reset: outputs clear before any clock edge
    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++; if (start_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_start: got %0b want 0", start_read); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        testsRun++; if (grant !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_grant: got %0b want 0", grant); end
        testsRun++; if (read_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h want 0", read_addr); end
        testsRun++; if (overflow !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_overflow: got %b want 00", overflow); end
        testsRun++; if (stray_beat !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stray: got %0b want 0", stray_beat); end
        testsRun++; if ({req0_rvalid, req1_rvalid, req0_rlast, req1_rlast} !== 4'b0) begin testsFailed++; $display("[TB] FAIL reset_route: got %b want 0000", {req0_rvalid, req1_rvalid, req0_rlast, req1_rlast}); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Lone req0 burst: two-cycle issue latency and beats routed only to req0
    task automatic test_single();
        resetDut();
        pulseReq(1'b1, 32'h1000, 32'd7, 1'b0, 32'h0, 32'd0);
        testsRun++; if (start_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_early_start: got %0b want 0", start_read); end
        tick();
        testsRun++; if (start_read !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_start: got %0b want 1", start_read); end
        testsRun++; if (read_addr !== 32'h1000) begin testsFailed++; $display("[TB] FAIL single_addr: got %h want 1000", read_addr); end
        testsRun++; if (read_len !== 32'd7) begin testsFailed++; $display("[TB] FAIL single_len: got %0d want 7", read_len); end
        testsRun++; if (read_size !== 3'd2 || read_burst !== 2'b01) begin testsFailed++; $display("[TB] FAIL single_size_burst: got %0d/%0d want 2/1", read_size, read_burst); end
        testsRun++; if (grant !== 1'b0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_grant_busy: got %0b/%0b want 0/1", grant, busy); end
        tick();
        testsRun++; if (start_read !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_start_width: got %0b want 0", start_read); end
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1;
            rlast  = (k == 7);
            rdata  = 32'hA0 + 32'(k);
            #1;
            testsRun++; if (req0_rvalid !== 1'b1 || req1_rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_beat%0d_valid: got r0=%0b r1=%0b want 1/0", k, req0_rvalid, req1_rvalid); end
            testsRun++; if (req0_rlast !== (k == 7) || req1_rlast !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_beat%0d_last: got r0=%0b r1=%0b want %0b/0", k, req0_rlast, req1_rlast, (k == 7)); end
            testsRun++; if (req_rdata !== 32'hA0 + 32'(k)) begin testsFailed++; $display("[TB] FAIL single_beat%0d_data: got %h want %h", k, req_rdata, 32'hA0 + 32'(k)); end
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_busy_end: got %0b want 0", busy); end
    endtask

    // Simultaneous commands: first tie to req0, second (after a req0 grant) to req1
    task automatic test_simultaneous();
        resetDut();
        pulseReq(1'b1, 32'h0, 32'd1, 1'b1, 32'h2000, 32'd1);
        tick();
        testsRun++; if (start_read !== 1'b1 || grant !== 1'b0 || read_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL sim_first: got start=%0b grant=%0b addr=%h want 1/0/0", start_read, grant, read_addr); end
        tick();
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1;
            rlast  = (k == 1);
            #1;
            testsRun++; if (req0_rvalid !== 1'b1 || req1_rvalid !== 1'b0 || req0_rlast !== (k == 1)) begin testsFailed++; $display("[TB] FAIL sim_r0_beat%0d: got v0=%0b v1=%0b l0=%0b", k, req0_rvalid, req1_rvalid, req0_rlast); end
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        testsRun++; if (start_read !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL sim_gap: got start=%0b busy=%0b want 0/0", start_read, busy); end
        tick();
        testsRun++; if (start_read !== 1'b1 || grant !== 1'b1 || read_addr !== 32'h2000) begin testsFailed++; $display("[TB] FAIL sim_second: got start=%0b grant=%0b addr=%h want 1/1/2000", start_read, grant, read_addr); end
        tick();
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1;
            rlast  = (k == 1);
            #1;
            testsRun++; if (req1_rvalid !== 1'b1 || req0_rvalid !== 1'b0 || req1_rlast !== (k == 1) || req0_rlast !== 1'b0) begin testsFailed++; $display("[TB] FAIL sim_r1_beat%0d: got v0=%0b v1=%0b l1=%0b", k, req0_rvalid, req1_rvalid, req1_rlast); end
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        pulseReq(1'b1, 32'h40, 32'd0, 1'b0, 32'h0, 32'd0);
        tick();
        tick();
        driveBeats(1);
        pulseReq(1'b1, 32'h500, 32'd0, 1'b1, 32'h600, 32'd0);
        tick();
        testsRun++; if (grant !== 1'b1 || read_addr !== 32'h600) begin testsFailed++; $display("[TB] FAIL sim_pair2_first: got grant=%0b addr=%h want 1/600", grant, read_addr); end
        tick();
        driveBeats(1);
        tick();
        testsRun++; if (start_read !== 1'b1 || grant !== 1'b0 || read_addr !== 32'h500) begin testsFailed++; $display("[TB] FAIL sim_pair2_second: got start=%0b grant=%0b addr=%h want 1/0/500", start_read, grant, read_addr); end
        tick();
        driveBeats(1);
    endtask

    // Second req1 command while its slot is occupied is dropped and flagged
    task automatic test_overflow();
        resetDut();
        pulseReq(1'b1, 32'h3000, 32'd3, 1'b0, 32'h0, 32'd0);
        tick();
        tick();
        pulseReq(1'b0, 32'h0, 32'd0, 1'b1, 32'h100, 32'd0);
        testsRun++; if (overflow !== 2'b00) begin testsFailed++; $display("[TB] FAIL ovf_first_ok: got %b want 00", overflow); end
        pulseReq(1'b0, 32'h0, 32'd0, 1'b1, 32'h200, 32'd0);
        testsRun++; if (overflow !== 2'b10) begin testsFailed++; $display("[TB] FAIL ovf_flag: got %b want 10", overflow); end
        driveBeats(4);
        tick();
        testsRun++; if (start_read !== 1'b1 || grant !== 1'b1 || read_addr !== 32'h100) begin testsFailed++; $display("[TB] FAIL ovf_kept_old: got start=%0b grant=%0b addr=%h want 1/1/100", start_read, grant, read_addr); end
        tick();
        driveBeats(1);
        tick();
        testsRun++; if (start_read !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_no_extra: got start=%0b busy=%0b want 0/0", start_read, busy); end
    endtask

    // req0 refills its own slot in the cycle it is granted
    task automatic test_rerequest();
        resetDut();
        pulseReq(1'b1, 32'h300, 32'd0, 1'b0, 32'h0, 32'd0);
        pulseReq(1'b1, 32'h400, 32'd0, 1'b0, 32'h0, 32'd0);
        testsRun++; if (start_read !== 1'b1 || read_addr !== 32'h300) begin testsFailed++; $display("[TB] FAIL rereq_first: got start=%0b addr=%h want 1/300", start_read, read_addr); end
        tick();
        driveBeats(1);
        testsRun++; if (start_read !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rereq_gap: got start=%0b busy=%0b want 0/0", start_read, busy); end
        tick();
        testsRun++; if (start_read !== 1'b1 || grant !== 1'b0 || read_addr !== 32'h400) begin testsFailed++; $display("[TB] FAIL rereq_second: got start=%0b grant=%0b addr=%h want 1/0/400", start_read, grant, read_addr); end
        tick();
        driveBeats(1);
        testsRun++; if (overflow !== 2'b00) begin testsFailed++; $display("[TB] FAIL rereq_overflow: got %b want 00", overflow); end
    endtask

    // rvalid while idle is not routed and sets the sticky stray flag
    task automatic test_stray();
        resetDut();
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'hAB;
        #1;
        testsRun++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0 || req0_rlast !== 1'b0 || req1_rlast !== 1'b0) begin testsFailed++; $display("[TB] FAIL stray_route: got v0=%0b v1=%0b want 0/0", req0_rvalid, req1_rvalid); end
        testsRun++; if (stray_beat !== 1'b0) begin testsFailed++; $display("[TB] FAIL stray_before: got %0b want 0", stray_beat); end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        tick();
        testsRun++; if (stray_beat !== 1'b1) begin testsFailed++; $display("[TB] FAIL stray_flag: got %0b want 1", stray_beat); end
    endtask

    // Reset during a burst with req1 queued: everything clears and the queued command is lost
    task automatic test_reset_mid_burst();
        resetDut();
        pulseReq(1'b1, 32'h800, 32'd7, 1'b0, 32'h0, 32'd0);
        tick();
        tick();
        pulseReq(1'b0, 32'h0, 32'd0, 1'b1, 32'h900, 32'd0);
        driveBeats(2);
        rvalid = 1'b1;
        rdata  = 32'h2;
        #1;
        rst_n = 1'b0;
        #1;
        testsRun++; if (start_read !== 1'b0 || busy !== 1'b0 || grant !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_ctrl: got start=%0b busy=%0b grant=%0b want 0/0/0", start_read, busy, grant); end
        testsRun++; if (read_addr !== 32'h0 || read_len !== 32'h0) begin testsFailed++; $display("[TB] FAIL rstmid_cmd: got addr=%h len=%0d want 0/0", read_addr, read_len); end
        testsRun++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_route: got v0=%0b v1=%0b want 0/0", req0_rvalid, req1_rvalid); end
        rvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            testsRun++; if (start_read !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_idle%0d: got start=%0b busy=%0b want 0/0", c, start_read, busy); end
        end
        rvalid = 1'b1;
        rlast  = 1'b1;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        testsRun++; if (stray_beat !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_stray: got %0b want 1", stray_beat); end
        pulseReq(1'b0, 32'h0, 32'd0, 1'b1, 32'h700, 32'd0);
        tick();
        testsRun++; if (start_read !== 1'b1 || grant !== 1'b1 || read_addr !== 32'h700) begin testsFailed++; $display("[TB] FAIL rstmid_new: got start=%0b grant=%0b addr=%h want 1/1/700", start_read, grant, read_addr); end
        tick();
        driveBeats(1);
    endtask

    // Run every scenario in order and print the summary
    initial begin
        rst_n      = 1'b1;
        req0_start = 1'b0;
        req1_start = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_len   = '0;
        req1_len   = '0;
        req0_size  = 3'd2;
        req1_size  = 3'd2;
        req0_burst = 2'b01;
        req1_burst = 2'b01;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rdata      = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_rerequest();
        test_stray();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/axi_read_port_arbiter.md
# axi_read_port_arbiter

Shares one burst read channel (one `AXI_memory_master_burst_read_only` instance plus its memory read port) between two read command sources, such as the noise-estimation and Wiener memory readers. It captures each requester's one-cycle `start_read` command into a per-requester slot and arbitrates round-robin between the slots. It issues one burst at a time to the downstream read master and routes the returned beats (`rvalid`/`rlast`/`rdata`) to the owning requester only.

## Interface

- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, read data width
- LEN_WIDTH, 32, burst length field width (beats minus 1, as in the read master)

Ports; clock and reset are listed first:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- req0_start  in  1  one-cycle read command pulse from requester 0
- req0_addr  in  ADDR_WIDTH  burst start address; sampled with req0_start
- req0_len  in  LEN_WIDTH  burst length minus 1
- req0_size  in  3  AXI size
- req0_burst  in  2  AXI burst type
- req1_start, req1_addr, req1_len, req1_size, req1_burst  in  as above  requester 1
- start_read  out  1  one-cycle command pulse to the read master
- read_addr  out  ADDR_WIDTH  granted command address
- read_len  out  LEN_WIDTH  granted command length
- read_size  out  3  granted command size
- read_burst  out  2  granted command burst type
- rvalid  in  1  read beat valid from memory
- rlast  in  1  last beat of burst
- rdata  in  DATA_WIDTH  read beat data
- req0_rvalid, req1_rvalid  out  1 each  beat valid routed to the owner
- req0_rlast, req1_rlast  out  1 each  last-beat flag routed to the owner
- req_rdata  out  DATA_WIDTH  rdata passed through combinationally, shared by both requesters
- grant  out  1  index of the current owner; valid while busy=1
- busy  out  1  a burst is being issued or is in flight
- overflow  out  2  sticky; bit i set when requester i's command was dropped
- stray_beat  out  1  sticky; set when rvalid arrives with no burst in flight

## Operation

- Each requester has one slot: a pending bit plus registered addr/len/size/burst.
- Capture on reqi_start:
  - If the slot is empty, or the slot is being granted in the same cycle, the slot loads the new command and pending is set.
  - Otherwise the new command is dropped, the old command is kept, and overflow[i] is set.
- State machine with three states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when any pending bit is set. Choose the winner, load the read_* registers from its slot, clear its pending bit, and set grant.
  - ISSUE → WAIT unconditionally. start_read=1 only while in ISSUE.
  - WAIT → IDLE on rvalid & rlast.
- Arbitration:
  - Only one requester pending: that requester wins.
  - Both pending: the requester that was not granted last wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- A command captured in the same cycle it arrives is not visible to arbitration until the next cycle.
- Routing:
  - reqi_rvalid = rvalid & (state==WAIT) & (grant==i).
  - reqi_rlast = rlast & (state==WAIT) & (grant==i).
- rvalid in IDLE or ISSUE: the beat is not routed and stray_beat is set.
- overflow and stray_beat are cleared only by reset.
- The block has no backpressure; requesters must be able to accept every routed beat.

## Timing

- Reset values (asynchronous, immediate): every output is 0, both pending bits are 0, last_grant=1, state=IDLE.
- Request latency: reqi_start in cycle N puts start_read high in cycle N+2, provided the block is IDLE and the requester wins.
- read_addr/len/size/burst and grant are valid from the ISSUE cycle and stay stable until the next IDLE→ISSUE transition.
- The beat routing outputs are combinational from rvalid/rlast/rdata, with 0 cycles of latency.
- busy=1 in ISSUE and WAIT.
- The rlast beat is accepted in cycle M, and the state is IDLE in cycle M+1. If a command is pending, start_read fires in cycle M+2. The minimum gap between bursts is 2 cycles.
- A reqi_start in the cycle that slot i is granted is captured into the freed slot; no overflow.
- Reset asserted mid-burst: all state returns to reset values immediately. Pending commands are lost, and beats arriving afterwards set stray_beat.

## Test plan

1. **Single request.** After reset, req0_start at cycle 2 with addr=0x1000, len=7.
   - Required: start_read at cycle 4 with read_addr=0x1000, read_len=7, grant=0.
   - Required: 8 beats appear on req0_rvalid only, and req0_rlast is high on the 8th beat.
   - Required: busy falls the cycle after that rlast.
2. **Simultaneous requests.** req0 (0x0) and req1 (0x2000) pulse in the same cycle.
   - Required: the req0 burst is issued first; the req1 start_read comes 2 cycles after the req0 rlast.
   - Required: a second simultaneous pair is served in the order req1, then req0.
3. **Overflow.** req1 pulses twice (0x100, then 0x200) while the req0 burst is in WAIT.
   - Required: overflow=2'b10, and the issued req1 burst has read_addr=0x100.
4. **Re-request on grant.** req0 pulses again in its own IDLE→ISSUE cycle.
   - Required: no overflow, and the second burst is issued after the first completes.
5. **Stray beat.** rvalid=1 while IDLE.
   - Required: stray_beat=1 and both reqi_rvalid stay 0.
6. **Reset mid-burst.** Assert rst_n low at beat 3 of 8, with req1 pending.
   - Required: all outputs are 0 at once, and no start_read occurs after release until a new request arrives.
